riscv_decode_stage: RTL and testbench

- Decode stage between instruction fetch and the ALU/execute stage.
- Accepts one RV32I instruction per cycle over a valid/ready handshake. Decodes it into an EXEC_FUN opcode and ALU operands, and reads the register file.
- Tracks pending register writes with a scoreboard, stalling on RAW hazards.
- Presents the result to execute through a registered ID/EX pipeline stage with its own valid/ready handshake.

---
 rtl/riscv_constants.sv | 90 +++++++++
 rtl/riscv_decoder.sv | 134 +++++++++++++
 rtl/riscv_decode_stage.sv | 119 +++++++++++
 tb/tb_riscv_decode_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_constants.sv
// Shared RV32I decode encodings plus the EXEC_FUN/WB_SEL enums and the decoded-instruction struct.
// Pure declarations; no timing or flow control here.
package riscv_constants;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_SLL  = 5'd2,
      ALU_SLT  = 5'd3,
      ALU_SLTU = 5'd4,
      ALU_XOR  = 5'd5,
      ALU_SRL  = 5'd6,
      ALU_SRA  = 5'd7,
      ALU_OR   = 5'd8,
      ALU_AND  = 5'd9,
      ALU_BEQ  = 5'd10,
      ALU_BNE  = 5'd11,
      ALU_BLT  = 5'd12,
      ALU_BGE  = 5'd13,
      ALU_BLTU = 5'd14,
      ALU_BGEU = 5'd15,
      ALU_JALR = 5'd16
   } exec_fun_t;

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_MEM  = 2'd2,
      WB_PC4  = 2'd3
   } wb_sel_t;

   typedef enum logic [1:0] {
      OP1_RS1  = 2'd0,
      OP1_PC   = 2'd1,
      OP1_ZERO = 2'd2
   } op1_sel_t;

   typedef enum logic [1:0] {
      OP2_RS2  = 2'd0,
      OP2_IMM  = 2'd1,
      OP2_FOUR = 2'd2
   } op2_sel_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      exec_fun_t   exec_fun;
      op1_sel_t    op1_sel;
      op2_sel_t    op2_sel;
      logic [31:0] imm;
      logic [31:0] target;
      logic [4:0]  rd;
      logic        wb_en;
      wb_sel_t     wb_sel;
      logic        mem_wen;
      logic        jump;
      logic        branch;
      logic        illegal;
      logic        uses_rs1;
      logic        uses_rs2;
   } dec_t;

endpackage

// File: rtl/riscv_decoder.sv
// Combinational RV32I decoder: instruction word and PC in, control, operand selects and immediates out.
// Zero latency, no flow control; illegal encodings are neutralised so they never write or stall.
module riscv_decoder
   import riscv_constants::*;
(
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output dec_t        dec
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign shamt  = {27'b0, inst[24:20]};

   always_comb begin
      dec          = '0;
      dec.exec_fun = ALU_ADD;
      dec.op1_sel  = OP1_RS1;
      dec.op2_sel  = OP2_IMM;
      dec.wb_sel   = WB_NONE;
      dec.rd       = inst[11:7];
      dec.imm      = imm_i;
      case (opcode)
         OPC_OP_IMM, OPC_OP: begin
            dec.uses_rs1 = 1'b1;
            dec.wb_en    = 1'b1;
            dec.wb_sel   = WB_ALU;
            if (opcode == OPC_OP) begin
               dec.uses_rs2 = 1'b1;
               dec.op2_sel  = OP2_RS2;
               dec.illegal  = (funct7 != F7_BASE);
            end
            case (funct3)
               F3_ADD: begin
                  dec.exec_fun = ALU_ADD;
                  if (opcode == OPC_OP && funct7 == F7_ALT) begin
                     dec.exec_fun = ALU_SUB;
                     dec.illegal  = 1'b0;
                  end
               end
               F3_SLL: begin
                  dec.exec_fun = ALU_SLL;
                  dec.imm      = shamt;
                  dec.illegal  = (funct7 != F7_BASE);
               end
               F3_SLT:  dec.exec_fun = ALU_SLT;
               F3_SLTU: dec.exec_fun = ALU_SLTU;
               F3_XOR:  dec.exec_fun = ALU_XOR;
               F3_SR: begin
                  dec.imm      = shamt;
                  dec.exec_fun = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  dec.illegal  = (funct7 != F7_BASE) && (funct7 != F7_ALT);
               end
               F3_OR:   dec.exec_fun = ALU_OR;
               default: dec.exec_fun = ALU_AND;
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.op1_sel = (opcode == OPC_LUI) ? OP1_ZERO : OP1_PC;
            dec.imm     = imm_u;
            dec.wb_en   = 1'b1;
            dec.wb_sel  = WB_ALU;
         end
         OPC_LOAD: begin
            dec.uses_rs1 = 1'b1;
            dec.wb_en    = 1'b1;
            dec.wb_sel   = WB_MEM;
            dec.illegal  = (funct3 == 3'd3) || (funct3 > 3'd5);
         end
         OPC_STORE: begin
            dec.uses_rs1 = 1'b1;
            dec.uses_rs2 = 1'b1;
            dec.imm      = imm_s;
            dec.mem_wen  = 1'b1;
            dec.illegal  = (funct3 > 3'd2);
         end
         OPC_BRANCH: begin
            dec.uses_rs1 = 1'b1;
            dec.uses_rs2 = 1'b1;
            dec.op2_sel  = OP2_RS2;
            dec.branch   = 1'b1;
            case (funct3)
               F3_BEQ:  dec.exec_fun = ALU_BEQ;
               F3_BNE:  dec.exec_fun = ALU_BNE;
               F3_BLT:  dec.exec_fun = ALU_BLT;
               F3_BGE:  dec.exec_fun = ALU_BGE;
               F3_BLTU: dec.exec_fun = ALU_BLTU;
               F3_BGEU: dec.exec_fun = ALU_BGEU;
               default: dec.illegal  = 1'b1;
            endcase
         end
         OPC_JAL: begin
            dec.op1_sel = OP1_PC;
            dec.op2_sel = OP2_FOUR;
            dec.jump    = 1'b1;
            dec.wb_en   = 1'b1;
            dec.wb_sel  = WB_ALU;
         end
         OPC_JALR: begin
            dec.uses_rs1 = 1'b1;
            dec.exec_fun = ALU_JALR;
            dec.wb_en    = 1'b1;
            dec.wb_sel   = WB_PC4;
            dec.illegal  = (funct3 != 3'd0);
         end
         default: dec.illegal = 1'b1;
      endcase
      // Illegal words flow down the pipe as harmless no-ops flagged for execute.
      if (dec.illegal) begin
         dec.exec_fun = ALU_ADD;
         dec.wb_en    = 1'b0;
         dec.wb_sel   = WB_NONE;
         dec.mem_wen  = 1'b0;
         dec.jump     = 1'b0;
         dec.branch   = 1'b0;
         dec.uses_rs1 = 1'b0;
         dec.uses_rs2 = 1'b0;
      end
      if (dec.rd == 5'd0) dec.wb_en = 1'b0;
      dec.target = pc + (dec.jump ? imm_j : imm_b);
   end

endmodule

// File: rtl/riscv_decode_stage.sv
// Decode stage: RAW scoreboard, fetch handshake and ID/EX register; one cycle from accept to ex_valid.
// Backpressure: id_ready drops on hazard, flush, or a held ID/EX slot; ID/EX holds while ex_ready is low.
module riscv_decode_stage
   import riscv_constants::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int NUM_REGS    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_valid,
   input  logic [31:0]            if_inst,
   input  logic [WORD_LENGTH-1:0] if_pc,
   output logic                   id_ready,
   output logic [4:0]             rs1_addr,
   output logic [4:0]             rs2_addr,
   input  logic [WORD_LENGTH-1:0] rs1_rdata,
   input  logic [WORD_LENGTH-1:0] rs2_rdata,
   input  logic                   wb_en,
   input  logic [4:0]             wb_rd,
   input  logic                   flush,
   output logic                   ex_valid,
   input  logic                   ex_ready,
   output exec_fun_t              ex_exec_fun,
   output logic [WORD_LENGTH-1:0] ex_data1,
   output logic [WORD_LENGTH-1:0] ex_data2,
   output logic [WORD_LENGTH-1:0] ex_store_data,
   output logic [WORD_LENGTH-1:0] ex_pc,
   output logic [WORD_LENGTH-1:0] ex_target,
   output logic [4:0]             ex_rd,
   output logic                   ex_wb_en,
   output wb_sel_t                ex_wb_sel,
   output logic                   ex_mem_wen,
   output logic                   ex_jump,
   output logic                   ex_branch,
   output logic                   ex_illegal
);

   dec_t                   dec;
   logic [NUM_REGS-1:0]    busy, busy_nxt;
   logic                   hazard, issue;
   logic [WORD_LENGTH-1:0] data1, data2;

   riscv_decoder u_decoder (
      .inst (if_inst),
      .pc   (if_pc),
      .dec  (dec)
   );

   assign rs1_addr = if_inst[19:15];
   assign rs2_addr = if_inst[24:20];

   // Busy bits are read registered, so a retirement in cycle t unblocks at t+1.
   assign hazard   = if_valid && ((dec.uses_rs1 && busy[rs1_addr]) ||
                                  (dec.uses_rs2 && busy[rs2_addr]));
   assign id_ready = (!ex_valid || ex_ready) && !hazard && !flush;
   assign issue    = if_valid && id_ready;

   always_comb begin
      busy_nxt = busy;
      if (wb_en) busy_nxt[wb_rd] = 1'b0;
      if (issue && dec.wb_en) busy_nxt[dec.rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      case (dec.op1_sel)
         OP1_PC:   data1 = if_pc;
         OP1_ZERO: data1 = '0;
         default:  data1 = rs1_rdata;
      endcase
      case (dec.op2_sel)
         OP2_RS2:  data2 = rs2_rdata;
         OP2_FOUR: data2 = WORD_LENGTH'(4);
         default:  data2 = dec.imm;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy          <= '0;
         ex_valid      <= 1'b0;
         ex_exec_fun   <= ALU_ADD;
         ex_data1      <= '0;
         ex_data2      <= '0;
         ex_store_data <= '0;
         ex_pc         <= '0;
         ex_target     <= '0;
         ex_rd         <= '0;
         ex_wb_en      <= 1'b0;
         ex_wb_sel     <= WB_NONE;
         ex_mem_wen    <= 1'b0;
         ex_jump       <= 1'b0;
         ex_branch     <= 1'b0;
         ex_illegal    <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (issue) begin
            ex_valid      <= 1'b1;
            ex_exec_fun   <= dec.exec_fun;
            ex_data1      <= data1;
            ex_data2      <= data2;
            ex_store_data <= rs2_rdata;
            ex_pc         <= if_pc;
            ex_target     <= dec.target;
            ex_rd         <= dec.rd;
            ex_wb_en      <= dec.wb_en;
            ex_wb_sel     <= dec.wb_sel;
            ex_mem_wen    <= dec.mem_wen;
            ex_jump       <= dec.jump;
            ex_branch     <= dec.branch;
            ex_illegal    <= dec.illegal;
         end else if (ex_ready) begin
            ex_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: hand-encoded instructions with hand-computed expected fields.
module tb_riscv_decode_stage;
   import riscv_constants::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_valid = 1'b0;
   logic [31:0] if_inst = 32'h0;
   logic [31:0] if_pc = 32'h0;
   logic        id_ready;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_rdata = 32'h0;
   logic [31:0] rs2_rdata = 32'h0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic        flush = 1'b0;
   logic        ex_valid;
   logic        ex_ready = 1'b1;
   exec_fun_t   ex_exec_fun;
   logic [31:0] ex_data1, ex_data2, ex_store_data, ex_pc, ex_target;
   logic [4:0]  ex_rd;
   logic        ex_wb_en;
   wb_sel_t     ex_wb_sel;
   logic        ex_mem_wen, ex_jump, ex_branch, ex_illegal;

   int n_chk = 0;
   int n_err = 0;

   riscv_decode_stage #(.WORD_LENGTH(32), .NUM_REGS(32)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
      .wb_en(wb_en), .wb_rd(wb_rd), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_exec_fun(ex_exec_fun),
      .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_store_data(ex_store_data),
      .ex_pc(ex_pc), .ex_target(ex_target), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
      .ex_wb_sel(ex_wb_sel), .ex_mem_wen(ex_mem_wen), .ex_jump(ex_jump),
      .ex_branch(ex_branch), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge, then leave 1 time unit before any input change.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] inst, input logic [31:0] pc);
      if_valid = 1'b1;
      if_inst  = inst;
      if_pc    = pc;
   endtask

   initial begin
      cyc(); cyc();
      rst = 1'b0;
      #1;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_exec_fun", ex_exec_fun, ALU_ADD);
      chk("rst_wb_sel", ex_wb_sel, WB_NONE);
      chk("rst_wb_en", ex_wb_en, 0);
      chk("rst_id_ready", id_ready, 1);

      // addi x1,x0,5
      cyc();
      present(32'h00500093, 32'h0);
      #1;
      chk("addi_ready", id_ready, 1);
      chk("addi_rs1_addr", rs1_addr, 0);
      cyc();
      chk("addi_valid", ex_valid, 1);
      chk("addi_fun", ex_exec_fun, ALU_ADD);
      chk("addi_d1", ex_data1, 32'h0);
      chk("addi_d2", ex_data2, 32'h5);
      chk("addi_rd", ex_rd, 1);
      chk("addi_wb_en", ex_wb_en, 1);
      chk("addi_wb_sel", ex_wb_sel, WB_ALU);

      // add x2,x1,x1 stalls until x1 retires, then issues the cycle after
      present(32'h00108133, 32'h4);
      #1;
      chk("raw_stall0", id_ready, 0);
      for (int i = 1; i < 3; i++) begin
         cyc();
         chk($sformatf("raw_stall%0d", i), id_ready, 0);
      end
      chk("raw_bubble", ex_valid, 0);
      cyc();
      wb_en = 1'b1;
      wb_rd = 5'd1;
      #1;
      chk("raw_same_cycle_wb", id_ready, 0);
      cyc();
      wb_en = 1'b0;
      rs1_rdata = 32'h1234;
      rs2_rdata = 32'h1234;
      #1;
      chk("raw_release", id_ready, 1);
      cyc();
      if_valid = 1'b0;
      chk("add_valid", ex_valid, 1);
      chk("add_fun", ex_exec_fun, ALU_ADD);
      chk("add_d1", ex_data1, 32'h1234);
      chk("add_d2", ex_data2, 32'h1234);
      chk("add_rd", ex_rd, 2);

      // xori x5,x6,-1 then hold ID/EX for three cycles
      present(32'hFFF34293, 32'h8);
      rs1_rdata = 32'hA5A50000;
      cyc();
      present(32'h123453B7, 32'hC);
      rs1_rdata = 32'h0;
      ex_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp_ready%0d", i), id_ready, 0);
         chk($sformatf("bp_valid%0d", i), ex_valid, 1);
         chk($sformatf("bp_fun%0d", i), ex_exec_fun, ALU_XOR);
         chk($sformatf("bp_d1_%0d", i), ex_data1, 32'hA5A50000);
         chk($sformatf("bp_d2_%0d", i), ex_data2, 32'hFFFFFFFF);
         chk($sformatf("bp_pc%0d", i), ex_pc, 32'h8);
         cyc();
      end
      ex_ready = 1'b1;
      #1;
      chk("bp_release_ready", id_ready, 1);
      cyc();
      if_valid = 1'b0;
      chk("lui_valid", ex_valid, 1);
      chk("lui_d1", ex_data1, 32'h0);
      chk("lui_d2", ex_data2, 32'h12345000);
      chk("lui_rd", ex_rd, 7);

      // beq x3,x4,-8 at 0x100
      present(32'hFE418CE3, 32'h100);
      #1;
      chk("beq_rs1_addr", rs1_addr, 3);
      chk("beq_rs2_addr", rs2_addr, 4);
      cyc();
      chk("beq_fun", ex_exec_fun, ALU_BEQ);
      chk("beq_branch", ex_branch, 1);
      chk("beq_target", ex_target, 32'h000000F8);
      chk("beq_wb_en", ex_wb_en, 0);
      chk("beq_jump", ex_jump, 0);

      // flush kills the younger instruction
      present(32'h00200493, 32'h104);
      flush = 1'b1;
      #1;
      chk("flush_ready", id_ready, 0);
      cyc();
      flush = 1'b0;
      if_valid = 1'b0;
      chk("flush_ex_valid", ex_valid, 0);

      // jal x1,+16 at 0x40
      present(32'h010000EF, 32'h40);
      cyc();
      chk("jal_d1", ex_data1, 32'h40);
      chk("jal_d2", ex_data2, 32'h4);
      chk("jal_target", ex_target, 32'h50);
      chk("jal_jump", ex_jump, 1);
      chk("jal_wb_en", ex_wb_en, 1);
      chk("jal_wb_sel", ex_wb_sel, WB_ALU);
      present(32'h00008433, 32'h44);
      #1;
      chk("jal_busy_x1", id_ready, 0);

      // addi x0,x0,1 never marks x0 busy
      present(32'h00100013, 32'h48);
      cyc();
      chk("x0_wb_en", ex_wb_en, 0);
      present(32'h00200493, 32'h4C);
      #1;
      chk("x0_no_stall", id_ready, 1);
      cyc();
      chk("addi9_d2", ex_data2, 32'h2);

      // sw x10,12(x11)
      present(32'h00A5A623, 32'h50);
      rs1_rdata = 32'h1000;
      rs2_rdata = 32'hDEADBEEF;
      cyc();
      chk("sw_mem_wen", ex_mem_wen, 1);
      chk("sw_wb_en", ex_wb_en, 0);
      chk("sw_d1", ex_data1, 32'h1000);
      chk("sw_d2", ex_data2, 32'hC);
      chk("sw_store_data", ex_store_data, 32'hDEADBEEF);

      // lw x12,-4(x13)
      present(32'hFFC6A603, 32'h54);
      cyc();
      chk("lw_wb_sel", ex_wb_sel, WB_MEM);
      chk("lw_d2", ex_data2, 32'hFFFFFFFC);
      chk("lw_wb_en", ex_wb_en, 1);

      // srai x14,x15,3
      present(32'h4037D713, 32'h58);
      cyc();
      chk("srai_fun", ex_exec_fun, ALU_SRA);
      chk("srai_d2", ex_data2, 32'h3);

      // illegal word, then hold it with ex_ready low
      present(32'hFFFFFFFF, 32'h5C);
      cyc();
      ex_ready = 1'b0;
      chk("ill_flag", ex_illegal, 1);
      chk("ill_wb_en", ex_wb_en, 0);
      chk("ill_mem_wen", ex_mem_wen, 0);
      chk("ill_fun", ex_exec_fun, ALU_ADD);
      chk("ill_valid", ex_valid, 1);

      // add x16,x12,x0 stalls on x12; reset clears pipe and scoreboard
      present(32'h00060833, 32'h60);
      #1;
      chk("pre_rst_ready", id_ready, 0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      ex_ready = 1'b1;
      #1;
      chk("mid_rst_ex_valid", ex_valid, 0);
      chk("mid_rst_illegal", ex_illegal, 0);
      chk("mid_rst_busy_clear", id_ready, 1);
      cyc();
      if_valid = 1'b0;
      chk("post_rst_issue", ex_rd, 16);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
